// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use, branch/jump
// and data-memory wait hazards, with a bounded memory wait and a stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       i_ID_rs,
    input  logic [4:0]       i_ID_rt,
    input  logic             i_ID_uses_rt,
    input  logic             i_ID_Jump,
    input  logic             i_EX_MemRead,
    input  logic [4:0]       i_EX_rt,
    input  logic             i_EX_Branch_Taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_PC_hold,
    output logic             o_IF_ID_hold,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_flush,
    output logic             o_EX_MEM_hold,
    output logic             o_MEM_WB_flush,
    output logic [1:0]       o_state,
    output logic             o_error,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam logic [1:0]  ST_RUN      = 2'd0;
    localparam logic [1:0]  ST_MEM_WAIT = 2'd1;
    localparam logic [1:0]  ST_ERROR    = 2'd2;
    localparam logic [15:0] TIMEOUT_W   = 16'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [15:0]      wait_q, wait_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic loadUse, memStall, frozen, evalRows;
    logic pcHold, ifIdHold, ifIdFlush, idExFlush, exMemHold, memWbFlush;

    assign loadUse  = i_EX_MemRead && (i_EX_rt != 5'd0) &&
                      ((i_EX_rt == i_ID_rs) || (i_ID_uses_rt && (i_EX_rt == i_ID_rt)));
    assign memStall = i_mem_req && !i_mem_ready;

    // frozen: the whole front end waits on memory (or is dead in ERROR).
    // evalRows: the branch / load-use / jump priority chain is in effect.
    always_comb begin
        frozen   = 1'b0;
        evalRows = 1'b0;
        case (state_q)
            ST_RUN: begin
                frozen   = memStall;
                evalRows = !memStall;
            end
            ST_MEM_WAIT: begin
                frozen   = !i_mem_ready;
                evalRows = i_mem_ready;
            end
            ST_ERROR: frozen = 1'b1;
            default: ;
        endcase
    end

    // A taken branch suppresses the load-use hold so the IF/ID flush is never masked.
    always_comb begin
        pcHold     = frozen || (evalRows && !i_EX_Branch_Taken && loadUse);
        ifIdHold   = pcHold;
        ifIdFlush  = evalRows && (i_EX_Branch_Taken || (!loadUse && i_ID_Jump));
        idExFlush  = evalRows && (i_EX_Branch_Taken || loadUse);
        exMemHold  = frozen;
        memWbFlush = frozen;
    end

    assign o_PC_hold      = pcHold     && !reset;
    assign o_IF_ID_hold   = ifIdHold   && !reset;
    assign o_IF_ID_flush  = ifIdFlush  && !reset;
    assign o_ID_EX_flush  = idExFlush  && !reset;
    assign o_EX_MEM_hold  = exMemHold  && !reset;
    assign o_MEM_WB_flush = memWbFlush && !reset;
    assign o_state        = state_q;
    assign o_error        = (state_q == ST_ERROR);
    assign o_stall_cycles = stall_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_RUN: begin
                if (memStall) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = 16'd1;
                end else begin
                    wait_d  = 16'd0;
                end
            end
            ST_MEM_WAIT: begin
                if (!i_mem_ready) begin
                    if (wait_q >= TIMEOUT_W) state_d = ST_ERROR;
                    else                     wait_d  = wait_q + 16'd1;
                end else begin
                    state_d = ST_RUN;
                    wait_d  = 16'd0;
                end
            end
            ST_ERROR: ;
            default: begin
                state_d = ST_RUN;
                wait_d  = 16'd0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        if (o_PC_hold && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            wait_q  <= 16'd0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

endmodule
